// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array tile sequencer.
// Imported by the sequencer top, its drain unit and the bench.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } sa_state_e;

    localparam int SA_ROWS = 8;
    localparam int SA_DW   = 8;
    localparam int SA_ACCW = 32;

    function automatic logic [SA_DW-1:0] sa_lane(
        input logic [SA_ROWS*SA_DW-1:0] v,
        input int unsigned              r
    );
        return v[r*SA_DW +: SA_DW];
    endfunction

endpackage

// File: rtl/sa_seq_drain.sv
// Result drain: pops complete result vectors into the output buffer,
// tracks the pop count and watches for a stalled core.
module sa_seq_drain
    import sa_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int ACCW    = 32,
    parameter int ADDRW   = 10,
    parameter int LENW    = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  sa_state_e            state,
    input  logic                 start,
    input  logic [LENW-1:0]      len,
    input  logic [ADDRW-1:0]     obase,
    input  logic [ROWS*ACCW-1:0] core_rout,
    input  logic [ROWS-1:0]      core_rvalid,
    input  logic                 obuf_ready,
    output logic                 pop,
    output logic [ADDRW-1:0]     obuf_waddr,
    output logic [ROWS*ACCW-1:0] obuf_wdata,
    output logic                 drain_done,
    output logic                 timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [LENW-1:0] n;
    logic [TW-1:0]   tcnt;
    logic            active;
    logic            in_drain;

    assign in_drain = (state == DRAIN);
    assign active   = (state == FEED) || in_drain;

    // A vector is only taken when every lane is valid and there is room.
    assign pop = active && (&core_rvalid) && obuf_ready && (n < len);

    assign obuf_waddr = obase + ADDRW'(n);
    assign obuf_wdata = pop ? core_rout : '0;

    assign drain_done = (n == len) || (pop && ((n + 1'b1) == len));
    assign timeout    = in_drain && !pop && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n <= '0;
        end else if (start) begin
            n <= '0;
        end else if (pop) begin
            n <= n + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
        end else if (!in_drain || pop) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer: feeds K activation/weight vectors into the array
// and drains K result vectors into the output buffer.
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int DW      = 8,
    parameter int ACCW    = 32,
    parameter int ADDRW   = 10,
    parameter int LENW    = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LENW-1:0]      cmd_len,
    input  logic [ADDRW-1:0]     cmd_abase,
    input  logic [ADDRW-1:0]     cmd_wbase,
    input  logic [ADDRW-1:0]     cmd_obase,
    output logic                 buf_ren,
    output logic [ADDRW-1:0]     buf_raddr_a,
    output logic [ADDRW-1:0]     buf_raddr_w,
    input  logic [ROWS*DW-1:0]   buf_rdata_a,
    input  logic [ROWS*DW-1:0]   buf_rdata_w,
    output logic [ROWS*DW-1:0]   core_a,
    output logic [ROWS*DW-1:0]   core_w,
    output logic                 core_inpvalid,
    output logic                 core_outread,
    input  logic [ROWS*ACCW-1:0] core_rout,
    input  logic [ROWS-1:0]      core_rvalid,
    output logic                 obuf_we,
    output logic [ADDRW-1:0]     obuf_waddr,
    output logic [ROWS*ACCW-1:0] obuf_wdata,
    input  logic                 obuf_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    sa_state_e        state;
    sa_state_e        state_nx;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  fcnt;
    logic [ADDRW-1:0] abase_q;
    logic [ADDRW-1:0] wbase_q;
    logic [ADDRW-1:0] obase_q;
    logic             accept;
    logic             start;
    logic             zero_cmd;
    logic             rd_pend;
    logic             pop;
    logic             drain_done;
    logic             timeout;

    assign accept   = cmd_valid && cmd_ready;
    assign start    = accept && (cmd_len != '0);
    assign zero_cmd = accept && (cmd_len == '0);

    assign core_outread = pop;
    assign obuf_we      = pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FEED;
            FEED:    if (fcnt == len_q - 1'b1) state_nx = DRAIN;
            DRAIN: begin
                if (drain_done) state_nx = DONE;
                else if (timeout) state_nx = IDLE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == IDLE);
        busy        = (state != IDLE);
        done        = (state == DONE);
        buf_ren     = (state == FEED);
        buf_raddr_a = buf_ren ? abase_q + ADDRW'(fcnt) : '0;
        buf_raddr_w = buf_ren ? wbase_q + ADDRW'(fcnt) : '0;
    end

    // Read data lands one cycle after buf_ren; valid travels with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q         <= '0;
            fcnt          <= '0;
            abase_q       <= '0;
            wbase_q       <= '0;
            obase_q       <= '0;
            rd_pend       <= 1'b0;
            core_inpvalid <= 1'b0;
            core_a        <= '0;
            core_w        <= '0;
            err           <= 1'b0;
        end else begin
            if (start) begin
                len_q   <= cmd_len;
                abase_q <= cmd_abase;
                wbase_q <= cmd_wbase;
                obase_q <= cmd_obase;
                fcnt    <= '0;
            end else if (buf_ren) begin
                fcnt <= fcnt + 1'b1;
            end
            rd_pend       <= buf_ren;
            core_inpvalid <= rd_pend;
            core_a        <= rd_pend ? buf_rdata_a : '0;
            core_w        <= rd_pend ? buf_rdata_w : '0;
            err           <= zero_cmd || timeout;
        end
    end

    sa_seq_drain #(
        .ROWS    (ROWS),
        .ACCW    (ACCW),
        .ADDRW   (ADDRW),
        .LENW    (LENW),
        .TIMEOUT (TIMEOUT)
    ) u_drain (
        .clk         (clk),
        .rstn        (rstn),
        .state       (state),
        .start       (start),
        .len         (len_q),
        .obase       (obase_q),
        .core_rout   (core_rout),
        .core_rvalid (core_rvalid),
        .obuf_ready  (obuf_ready),
        .pop         (pop),
        .obuf_waddr  (obuf_waddr),
        .obuf_wdata  (obuf_wdata),
        .drain_done  (drain_done),
        .timeout     (timeout)
    );

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Bench for sa_tile_sequencer: buffer and core models around the DUT,
// expected traffic derived from buffer contents and tile parameters.
module tb_sa_tile_sequencer;
    import sa_pkg::*;

    localparam int ROWS  = 8;
    localparam int DW    = 8;
    localparam int ACCW  = 32;
    localparam int ADDRW = 10;
    localparam int LENW  = 16;
    localparam int TO    = 16;
    localparam int DEPTH = 1 << ADDRW;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LENW-1:0]      cmd_len;
    logic [ADDRW-1:0]     cmd_abase;
    logic [ADDRW-1:0]     cmd_wbase;
    logic [ADDRW-1:0]     cmd_obase;
    logic                 buf_ren;
    logic [ADDRW-1:0]     buf_raddr_a;
    logic [ADDRW-1:0]     buf_raddr_w;
    logic [ROWS*DW-1:0]   buf_rdata_a;
    logic [ROWS*DW-1:0]   buf_rdata_w;
    logic [ROWS*DW-1:0]   core_a;
    logic [ROWS*DW-1:0]   core_w;
    logic                 core_inpvalid;
    logic                 core_outread;
    logic [ROWS*ACCW-1:0] core_rout;
    logic [ROWS-1:0]      core_rvalid;
    logic                 obuf_we;
    logic [ADDRW-1:0]     obuf_waddr;
    logic [ROWS*ACCW-1:0] obuf_wdata;
    logic                 obuf_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    always #5 clk = ~clk;

    sa_tile_sequencer #(
        .ROWS(ROWS), .DW(DW), .ACCW(ACCW),
        .ADDRW(ADDRW), .LENW(LENW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_abase(cmd_abase),
        .cmd_wbase(cmd_wbase), .cmd_obase(cmd_obase),
        .buf_ren(buf_ren), .buf_raddr_a(buf_raddr_a),
        .buf_raddr_w(buf_raddr_w), .buf_rdata_a(buf_rdata_a),
        .buf_rdata_w(buf_rdata_w), .core_a(core_a), .core_w(core_w),
        .core_inpvalid(core_inpvalid), .core_outread(core_outread),
        .core_rout(core_rout), .core_rvalid(core_rvalid),
        .obuf_we(obuf_we), .obuf_waddr(obuf_waddr),
        .obuf_wdata(obuf_wdata), .obuf_ready(obuf_ready),
        .busy(busy), .done(done), .err(err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROWS*ACCW-1:0] vsum(
        input logic [ROWS*DW-1:0] a,
        input logic [ROWS*DW-1:0] w
    );
        logic [ROWS*ACCW-1:0] s;
        s = '0;
        for (int r = 0; r < ROWS; r++)
            s[r*ACCW +: ACCW] = ACCW'(sa_lane(a, r)) + ACCW'(sa_lane(w, r));
        return s;
    endfunction

    logic [ROWS*DW-1:0] a_mem [DEPTH];
    logic [ROWS*DW-1:0] w_mem [DEPTH];

    always @(posedge clk) begin
        if (buf_ren) begin
            buf_rdata_a <= a_mem[buf_raddr_a];
            buf_rdata_w <= w_mem[buf_raddr_w];
        end
    end

    // Core: a result FIFO, each entry the lane-wise sum of one input pair.
    logic [ROWS*ACCW-1:0] res_mem [64];
    int                   wp;
    int                   rp;
    logic [ROWS-1:0]      rv_mask;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= 0;
            rp <= 0;
        end else begin
            if (core_inpvalid) begin
                res_mem[wp % 64] <= vsum(core_a, core_w);
                wp <= wp + 1;
            end
            if (core_outread) rp <= rp + 1;
        end
    end

    assign core_rvalid = (wp != rp) ? rv_mask : '0;
    assign core_rout   = res_mem[rp % 64];

    int cur_ab, cur_wb, cur_ob;
    int ren_cnt, in_cnt, wr_cnt, done_cnt, err_cnt;
    int cyc = 0;
    int last_ren_cyc, err_cyc;

    always @(negedge clk) begin
        if (rstn) begin
            cyc++;
            if (buf_ren) begin
                chk("raddr_a", buf_raddr_a, (cur_ab + ren_cnt) % DEPTH);
                chk("raddr_w", buf_raddr_w, (cur_wb + ren_cnt) % DEPTH);
                ren_cnt++;
                last_ren_cyc = cyc;
            end
            if (core_inpvalid) begin
                chk("core_a", core_a, a_mem[(cur_ab + in_cnt) % DEPTH]);
                chk("core_w", core_w, w_mem[(cur_wb + in_cnt) % DEPTH]);
                in_cnt++;
            end
            chk("outread_we", core_outread, obuf_we);
            if (!obuf_ready || rv_mask != '1)
                chk("pop_gate", obuf_we, 1'b0);
            if (obuf_we) begin
                chk("waddr", obuf_waddr, (cur_ob + wr_cnt) % DEPTH);
                chk("wdata", obuf_wdata,
                    vsum(a_mem[(cur_ab + wr_cnt) % DEPTH],
                         w_mem[(cur_wb + wr_cnt) % DEPTH]));
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic set_async(input logic rdy, input logic [ROWS-1:0] m);
        @(posedge clk);
        #1;
        obuf_ready = rdy;
        rv_mask    = m;
    endtask

    task automatic start_cmd(input int k, input int ab, input int wb,
                             input int ob);
        @(negedge clk);
        cur_ab = ab; cur_wb = wb; cur_ob = ob;
        ren_cnt = 0; in_cnt = 0; wr_cnt = 0;
        done_cnt = 0; err_cnt = 0;
        cmd_len   = LENW'(k);
        cmd_abase = ADDRW'(ab);
        cmd_wbase = ADDRW'(wb);
        cmd_obase = ADDRW'(ob);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input bit rnd);
        int c;
        c = 0;
        while (done_cnt == 0 && err_cnt == 0 && c < 500) begin
            @(posedge clk);
            #1;
            if (rnd) obuf_ready = ($urandom_range(0, 3) != 0);
            c++;
        end
        obuf_ready = 1'b1;
        chk({tag, "_finished"}, c < 500, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_tile(input string tag, input int k);
        chk({tag, "_ren"},   ren_cnt, k);
        chk({tag, "_inp"},   in_cnt, k);
        chk({tag, "_wr"},    wr_cnt, k);
        chk({tag, "_done"},  done_cnt, 1);
        chk({tag, "_err"},   err_cnt, 0);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"},  busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int c, w0, k;
        for (int i = 0; i < DEPTH; i++) begin
            a_mem[i] = {$urandom, $urandom};
            w_mem[i] = {$urandom, $urandom};
        end
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_len = '0; cmd_abase = '0; cmd_wbase = '0; cmd_obase = '0;
        obuf_ready = 1'b1;
        rv_mask = '1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ren", buf_ren, 1'b0);
        chk("rst_inpvalid", core_inpvalid, 1'b0);
        chk("rst_we", obuf_we, 1'b0);
        chk("rst_done_err", {done, err}, 2'b00);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // K=4 with a stray command during FEED that must be ignored
        start_cmd(4, 0, 16, 32);
        cmd_valid = 1'b1;
        cmd_len = 16'd5;
        cmd_abase = 10'd500;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_end("k4", 1'b0);
        check_tile("k4", 4);

        // K=0 reports an error and never leaves IDLE
        start_cmd(0, 7, 8, 9);
        chk("k0_err_pulse", err, 1'b1);
        chk("k0_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk("k0_err_low", err, 1'b0);
        repeat (3) @(negedge clk);
        chk("k0_no_ren", ren_cnt, 0);
        chk("k0_err_cnt", err_cnt, 1);

        // K=3 with the output buffer stalled mid-drain
        start_cmd(3, 100, 200, 300);
        c = 0;
        while (wr_cnt < 1 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("k3_first_wr", c < 100, 1'b1);
        obuf_ready = 1'b0;
        w0 = wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("k3_hold", wr_cnt, w0);
        obuf_ready = 1'b1;
        wait_end("k3", 1'b0);
        check_tile("k3", 3);

        // K=2, core never answers: timeout 16 cycles into DRAIN
        set_async(1'b1, '0);
        start_cmd(2, 50, 60, 70);
        wait_end("to", 1'b0);
        chk("to_err_cnt", err_cnt, 1);
        chk("to_done_cnt", done_cnt, 0);
        chk("to_latency", err_cyc - (last_ren_cyc + 1), TO);
        chk("to_wr", wr_cnt, 0);
        chk("to_idle", cmd_ready, 1'b1);
        set_async(1'b1, '1);
        pulse_reset();

        // Read and write address wrap
        start_cmd(4, 1022, 1021, 1022);
        wait_end("wrap", 1'b0);
        check_tile("wrap", 4);

        // Partial rvalid must not pop
        set_async(1'b1, 8'hFE);
        start_cmd(2, 40, 60, 80);
        c = 0;
        while (in_cnt < 1 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("fe_no_pop", wr_cnt, 0);
        rv_mask = '1;
        wait_end("fe", 1'b0);
        check_tile("fe", 2);

        // Reset in the middle of FEED aborts silently
        start_cmd(8, 400, 500, 600);
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_outs",
            {busy, buf_ren, core_inpvalid, obuf_we, done, err},
            6'b0);
        chk("mid_rst_data", {core_a, buf_raddr_a}, '0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (25) @(negedge clk);
        chk("mid_no_done", done_cnt, 0);
        chk("mid_no_err", err_cnt, 0);

        // Random tiles with a jittery output buffer
        for (int t = 0; t < 8; t++) begin
            k = $urandom_range(1, 12);
            start_cmd(k, $urandom_range(0, DEPTH - 1),
                      $urandom_range(0, DEPTH - 1),
                      $urandom_range(0, DEPTH - 1));
            wait_end("rnd", 1'b1);
            check_tile("rnd", k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
